instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch unit driving the instruction ROM: owns the PC, reads one 16-bit word per cycle from the
//  combinational ROM, and hands {pc, instr} to decode over a valid/ready handshake through a small
//  prefetch buffer. Handles branch/jump redirects, halts on the halt word or an out-of-range PC.
// PARAMETERS
//  PC_W       8        PC / ROM address width (word addressed, +1 per instruction)
//  INSTR_W    16       instruction width
//  ROM_DEPTH  21       number of valid ROM words; PC >= ROM_DEPTH is out of range
//  RESET_PC   0        PC loaded at reset
//  HALT_WORD  16'h0000 instruction word that stops fetch
//  BUF_DEPTH  2        prefetch buffer entries (power of 2, >= 2)
// PORTS
//  clk             in   1        clock, rising edge
//  rst_n           in   1        asynchronous active-low reset
//  rom_pc          out  PC_W     address to ROM (= PC register)
//  rom_data        in   INSTR_W  ROM word at rom_pc, same cycle
//  redirect_valid  in   1        branch/jump taken this cycle
//  redirect_pc     in   PC_W     redirect target
//  id_valid        out  1        buffer head valid to decode
//  id_ready        in   1        decode accepts head
//  id_instr        out  INSTR_W  head instruction
//  id_pc           out  PC_W     PC of head instruction
//  halted          out  1        fetch stopped (state HALTED)
//  fetch_fault     out  1        sticky: halt caused by out-of-range PC
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, buffer empty, id_valid=0, id_instr=0, id_pc=0,
//   state=RUN, halted=0, fetch_fault=0. Fetch starts first edge after rst_n deasserts.
//  States: RUN, HALTED. halted is registered (==state HALTED).
//  deq = id_valid & id_ready. space = (count < BUF_DEPTH) | deq.
//  RUN, no redirect, space, pc < ROM_DEPTH:
//   rom_data != HALT_WORD -> enqueue {pc, rom_data}; pc <= pc+1 (mod 2^PC_W).
//   rom_data == HALT_WORD -> not enqueued; pc held; -> HALTED.
//  RUN, pc >= ROM_DEPTH: no enqueue, pc held, -> HALTED, fetch_fault<=1.
//  RUN, no space: stall; pc held, nothing enqueued.
//  Latency: word at pc appears as id_* on cycle after fetch (buffer output registered);
//   sustained 1 instr/cycle when id_ready=1.
//  Redirect (any state, highest priority): buffer flushed (count<=0), pc<=redirect_pc,
//   state<=RUN, fetch_fault<=0; no enqueue that cycle; id_valid=0 next cycle; first target
//   instr on id_* two cycles after redirect. A deq in the redirect cycle still completes.
//  HALTED: no fetch; buffer keeps draining to decode normally; leaves only on redirect or reset.
//  Buffer: FIFO order preserved; enqueue and deq same cycle with count==BUF_DEPTH is legal.
//   id_instr/id_pc hold value while id_valid=1 & id_ready=0.
//  Reset mid-operation: all state cleared immediately, in-flight entries discarded.
// STRUCTURE
//  Package mips_fetch_pkg: typedef enum {RUN, HALTED} fetch_state_t; typedef struct packed
//   {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr;} fetch_entry_t; localparam HALT_WORD default.
//  Sub-module fetch_buf: BUF_DEPTH-entry FIFO of fetch_entry_t with push/pop/flush, count,
//   registered head. Top holds PC register, FSM, fault flag.
// TESTING
//  1 Reset, id_ready=1, ROM words 1000,1011,1002 at 0..2 -> id_pc 0,1,2 on consecutive cycles
//    starting 2nd cycle after reset release, id_instr 1000,1011,1002.
//  2 Hold id_ready=0 for 5 cycles -> exactly 2 entries buffered, rom_pc frozen at 2, id_* stable;
//    release -> pcs 0,1,2,3 in order, no gap, no duplicate.
//  3 redirect_valid with redirect_pc=8 while buffer full -> next cycle id_valid=0, rom_pc=8;
//    following cycle id_pc=8, id_instr=mem[8]; no stale entries appear.
//  4 ROM word 0000 at pc 20 -> pcs up to 19 delivered, halted=1, rom_pc stays 20, fetch_fault=0;
//    redirect to 0 -> halted=0, fetch resumes at 0.
//  5 redirect_pc=25 (>=ROM_DEPTH) -> no delivery, halted=1, fetch_fault=1; redirect 3 clears both.
//  6 Assert rst_n=0 mid-stream with buffer full -> same-cycle id_valid=0, halted=0, rom_pc=0;
//    after release stream restarts at pc 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding and the
// {pc, instr} entry carried from the PC register through the prefetch buffer.
package mips_fetch_pkg;

  localparam int FETCH_PC_W    = 8;
  localparam int FETCH_INSTR_W = 16;
  localparam logic [FETCH_INSTR_W-1:0] DEF_HALT_WORD = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO between the PC stage and decode. The head is read straight
// from storage flops, so a pushed entry is visible on the cycle after the push.
module fetch_buf
  import mips_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(BUF_DEPTH):0]   count,
  output logic                         head_valid,
  output fetch_entry_t                 head
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t      mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_pop;

  assign do_pop = pop & (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // A pop in the flush cycle was already taken by decode; nothing to undo.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC, reads one ROM word per cycle, and queues {pc, instr}
// to decode. Redirects flush and restart; halt word or out-of-range PC stops fetch.
module instr_fetch
  import mips_fetch_pkg::*;
#(
  parameter int                 PC_W      = FETCH_PC_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter int                 ROM_DEPTH = 21,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = DEF_HALT_WORD,
  parameter int                 BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    rom_pc,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               halted,
  output logic               fetch_fault
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              push, flush;
  logic              deq, space, in_range, is_halt;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign deq      = id_valid & id_ready;
  assign space    = (count < BUF_FULL) | deq;
  assign in_range = ({1'b0, pc_q} < (PC_W+1)'(ROM_DEPTH));
  assign is_halt  = (rom_data == HALT_WORD);

  // State register: PC, FSM state and sticky fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next state: redirect always wins and restarts fetch
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (!in_range)            state_d = HALTED;
      else if (space && is_halt) state_d = HALTED;
    end
  end

  // Outputs / datapath control
  always_comb begin
    push    = 1'b0;
    flush   = redirect_valid;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
    end else if (state_q == RUN) begin
      if (!in_range) begin
        fault_d = 1'b1;
      end else if (space && !is_halt) begin
        push = 1'b1;
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  assign push_entry = '{pc: pc_q, instr: rom_data};

  fetch_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (deq),
    .flush      (flush),
    .count      (count),
    .head_valid (id_valid),
    .head       (head)
  );

  assign rom_pc      = pc_q;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign halted      = (state_q == HALTED);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, halt,
// out-of-range fault and asynchronous reset mid-stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_pc;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        halted;
  logic        fetch_fault;

  logic [15:0] rom [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_pc < 8'd32) ? rom[rom_pc[4:0]] : 16'hDEAD;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_pc         (rom_pc),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .halted         (halted),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    rom[1]  = 16'h1011;
    rom[20] = 16'h0000;

    // 1: reset values, then streaming with id_ready=1
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'd0;
    step(); step();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", 32'(id_instr), 32'd0);
    chk("rst_id_pc",    32'(id_pc),    32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_fault",    32'(fetch_fault), 32'd0);
    chk("rst_rom_pc",   32'(rom_pc),   32'd0);
    rst_n = 1'b1;
    step();
    chk("s1_valid0", 32'(id_valid), 32'd1);
    chk("s1_pc0",    32'(id_pc),    32'd0);
    chk("s1_instr0", 32'(id_instr), 32'h1000);
    step();
    chk("s1_pc1",    32'(id_pc),    32'd1);
    chk("s1_instr1", 32'(id_instr), 32'h1011);
    step();
    chk("s1_pc2",    32'(id_pc),    32'd2);
    chk("s1_instr2", 32'(id_instr), 32'h1002);

    // 2: backpressure from a fresh reset
    rst_n = 1'b0; id_ready = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("s2_valid",  32'(id_valid), 32'd1);
    chk("s2_rom_pc", 32'(rom_pc),   32'd2);
    chk("s2_hold_pc", 32'(id_pc),   32'd0);
    chk("s2_hold_instr", 32'(id_instr), 32'h1000);
    id_ready = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      step();
      chk("s2_valid_stream", 32'(id_valid), 32'd1);
      chk("s2_pc_order", 32'(id_pc), 32'(p));
    end

    // 3: redirect to 8 while buffer is full
    id_ready = 1'b0;
    step();
    chk("s3_full_rom_pc", 32'(rom_pc), 32'd5);
    chk("s3_full_head",   32'(id_pc),  32'd3);
    redirect_valid = 1'b1; redirect_pc = 8'd8;
    step();
    redirect_valid = 1'b0; id_ready = 1'b1;
    chk("s3_flush_valid", 32'(id_valid), 32'd0);
    chk("s3_rom_pc",      32'(rom_pc),   32'd8);
    step();
    chk("s3_tgt_valid", 32'(id_valid), 32'd1);
    chk("s3_tgt_pc",    32'(id_pc),    32'd8);
    chk("s3_tgt_instr", 32'(id_instr), 32'h1008);

    // 4: run into the halt word at pc 20
    for (int p = 9; p <= 19; p++) begin
      step();
      chk("s4_pc_seq", 32'(id_pc), 32'(p));
    end
    chk("s4_instr19", 32'(id_instr), 32'h1013);
    chk("s4_pre_halted", 32'(halted), 32'd0);
    step();
    chk("s4_halted",  32'(halted),      32'd1);
    chk("s4_valid",   32'(id_valid),    32'd0);
    chk("s4_rom_pc",  32'(rom_pc),      32'd20);
    chk("s4_fault",   32'(fetch_fault), 32'd0);
    step();
    chk("s4_stay_halted", 32'(halted), 32'd1);
    chk("s4_stay_rom_pc", 32'(rom_pc), 32'd20);
    redirect_valid = 1'b1; redirect_pc = 8'd0;
    step();
    redirect_valid = 1'b0;
    chk("s4_resume_halted", 32'(halted), 32'd0);
    chk("s4_resume_rom_pc", 32'(rom_pc), 32'd0);
    step();
    chk("s4_resume_pc",    32'(id_pc),    32'd0);
    chk("s4_resume_instr", 32'(id_instr), 32'h1000);

    // 5: redirect out of range, then recover
    redirect_valid = 1'b1; redirect_pc = 8'd25;
    step();
    redirect_valid = 1'b0;
    step();
    chk("s5_halted", 32'(halted),      32'd1);
    chk("s5_fault",  32'(fetch_fault), 32'd1);
    chk("s5_valid",  32'(id_valid),    32'd0);
    chk("s5_rom_pc", 32'(rom_pc),      32'd25);
    step();
    chk("s5_sticky", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 8'd3;
    step();
    redirect_valid = 1'b0;
    chk("s5_clr_halted", 32'(halted),      32'd0);
    chk("s5_clr_fault",  32'(fetch_fault), 32'd0);
    chk("s5_clr_rom_pc", 32'(rom_pc),      32'd3);
    step();
    chk("s5_pc3",    32'(id_pc),    32'd3);
    chk("s5_instr3", 32'(id_instr), 32'h1003);

    // 6: asynchronous reset with the buffer full
    id_ready = 1'b0;
    step(); step();
    chk("s6_full_valid", 32'(id_valid), 32'd1);
    rst_n = 1'b0; id_ready = 1'b1;
    #1;
    chk("s6_rst_valid",  32'(id_valid), 32'd0);
    chk("s6_rst_halted", 32'(halted),   32'd0);
    chk("s6_rst_rom_pc", 32'(rom_pc),   32'd0);
    chk("s6_rst_id_pc",  32'(id_pc),    32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("s6_restart_pc0", 32'(id_pc),    32'd0);
    chk("s6_restart_v",   32'(id_valid), 32'd1);
    step();
    chk("s6_restart_pc1",    32'(id_pc),    32'd1);
    chk("s6_restart_instr1", 32'(id_instr), 32'h1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
